// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, loader and memory-side signals around the instruction memory arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface imem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned IDX_W      = 10
);
    logic                  fetch_req_i;
    logic [ADDR_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_rvalid_o;
    logic [DATA_WIDTH-1:0] fetch_rdata_o;
    logic                  fetch_err_o;

    logic                  ld_req_i;
    logic [ADDR_WIDTH-1:0] ld_addr_i;
    logic [DATA_WIDTH-1:0] ld_wdata_i;
    logic                  ld_gnt_o;
    logic                  ld_err_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [IDX_W-1:0]      mem_idx_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  fetch_req_i, fetch_addr_i, ld_req_i, ld_addr_i, ld_wdata_i, mem_rdata_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        output ld_gnt_o, ld_err_o, mem_en_o, mem_we_o, mem_idx_o, mem_wdata_o
    );

    modport master (
        output fetch_req_i, fetch_addr_i, ld_req_i, ld_addr_i, ld_wdata_i, mem_rdata_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o, fetch_err_o,
        input  ld_gnt_o, ld_err_o, mem_en_o, mem_we_o, mem_idx_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory access controller: arbitrates fetch reads against
// loader writes, bounds fetch starvation, and turns bad fetch addresses into NOPs.
module imem_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_SIZE       = 1024,
    parameter int unsigned MAX_FETCH_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(MEM_SIZE);
    localparam int unsigned CNT_W = $clog2(MAX_FETCH_WAIT + 1);

    localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CNT_W-1:0]      WAIT_MAX = CNT_W'(MAX_FETCH_WAIT);
    localparam logic [ADDR_WIDTH-1:0] WORDS    = ADDR_WIDTH'(MEM_SIZE);

    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic             ld_err_q, ld_err_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic                  fetch_ok, ld_ok;
    logic                  fetch_gnt, ld_gnt;
    logic                  mem_en, mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Word-aligned and inside the array.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < WORDS);
    endfunction

    always_comb begin
        fetch_ok   = addr_ok(bus.fetch_addr_i);
        ld_ok      = addr_ok(bus.ld_addr_i);
        fetch_gnt  = bus.fetch_req_i && (!bus.ld_req_i || (wait_cnt_q == WAIT_MAX));
        ld_gnt     = bus.ld_req_i && !fetch_gnt;

        wait_cnt_d = wait_cnt_q;
        if (!bus.fetch_req_i || fetch_gnt) begin
            wait_cnt_d = '0;
        end else if (ld_gnt && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        rvalid_d  = fetch_gnt;
        err_d     = fetch_gnt && !fetch_ok;
        ld_err_d  = ld_gnt && !ld_ok;

        // Invalid accesses are granted but never reach the array.
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        if (fetch_gnt && fetch_ok) begin
            mem_en  = 1'b1;
            mem_idx = bus.fetch_addr_i[IDX_W+1:2];
        end else if (ld_gnt && ld_ok) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_idx   = bus.ld_addr_i[IDX_W+1:2];
            mem_wdata = bus.ld_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            ld_err_q   <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            ld_err_q   <= ld_err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.fetch_gnt_o    = fetch_gnt;
    assign bus.ld_gnt_o       = ld_gnt;
    assign bus.mem_en_o       = mem_en;
    assign bus.mem_we_o       = mem_we;
    assign bus.mem_idx_o      = mem_idx;
    assign bus.mem_wdata_o    = mem_wdata;
    assign bus.fetch_rvalid_o = rvalid_q;
    assign bus.fetch_err_o    = rvalid_q && err_q;
    assign bus.ld_err_o       = ld_err_q;
    // Memory data is passed straight through; only error responses are substituted.
    assign bus.fetch_rdata_o  = err_q ? NOP_INSN : bus.mem_rdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model and a behavioural memory.
module tb_imem_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned MS = 1024;
    localparam int unsigned MW = 4;
    localparam int unsigned IW = $clog2(MS);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IDX_W(IW)) bus ();

    imem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .MAX_FETCH_WAIT(MW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h0010_0093 ^ 32'(i * 32'h9E37_79B1);
    endfunction

    // Synchronous single-port array; controls captured mid-cycle, applied at the edge.
    logic [DW-1:0] ram [MS];
    logic          c_en, c_we;
    logic [IW-1:0] c_idx;
    logic [DW-1:0] c_wd;
    initial begin
        for (int i = 0; i < int'(MS); i++) ram[i] = init_word(i);
        bus.mem_rdata_i <= '0;
        forever begin
            @(negedge clk);
            c_en = bus.mem_en_o; c_we = bus.mem_we_o; c_idx = bus.mem_idx_o; c_wd = bus.mem_wdata_o;
            @(posedge clk);
            if (c_en) begin
                if (c_we) ram[c_idx] = c_wd;
                else      bus.mem_rdata_i <= ram[c_idx];
            end
        end
    end

    // Reference model state and expectations for the current cycle (e_*) and next cycle (n_*).
    logic [DW-1:0] ref_mem [MS];
    int            losses;
    logic          f_req, l_req;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          e_fgnt, e_lgnt, e_en, e_we;
    logic [IW-1:0] e_idx;
    logic [DW-1:0] e_wdata;
    logic          n_rvalid, n_err, n_lderr;
    logic [DW-1:0] n_rdata;

    function automatic bit in_range(input logic [AW-1:0] a);
        return (a % 4 == 0) && (a / 4 < MS);
    endfunction

    task automatic apply(input bit fr, input logic [AW-1:0] fa, input bit lr,
                         input logic [AW-1:0] la, input logic [DW-1:0] lw);
        bit fv, lv;
        f_req = fr; f_addr = fa; l_req = lr; l_addr = la; l_wdata = lw;
        bus.fetch_req_i = fr; bus.fetch_addr_i = fa;
        bus.ld_req_i = lr; bus.ld_addr_i = la; bus.ld_wdata_i = lw;
        fv = in_range(fa);
        lv = in_range(la);
        e_fgnt  = fr && (!lr || losses == int'(MW));
        e_lgnt  = lr && !e_fgnt;
        if (e_fgnt || !fr) losses = 0;
        else if (losses < int'(MW)) losses++;
        e_en    = (e_fgnt && fv) || (e_lgnt && lv);
        e_we    = e_lgnt && lv;
        e_idx   = !e_en ? '0 : (e_fgnt ? IW'(fa / 4) : IW'(la / 4));
        e_wdata = e_we ? lw : '0;
        n_rvalid = e_fgnt;
        n_err    = e_fgnt && !fv;
        n_rdata  = (e_fgnt && fv) ? ref_mem[IW'(fa / 4)] : 32'h0000_0013;
        n_lderr  = e_lgnt && !lv;
        if (e_we) ref_mem[IW'(la / 4)] = lw;
    endtask

    task automatic idle();
        apply(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return AW'(4 * $urandom_range(0, 31) + $urandom_range(1, 3));
        if (r == 1) return AW'(MS * 4 + 4 * $urandom_range(0, 1000));
        return AW'(4 * $urandom_range(0, 31));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        apply(1'b1, 32'h0, 1'b0, '0, '0);
        @(negedge clk);
        vectors++; if (bus.fetch_gnt_o !== 1'b1) begin miscompares++; $display("FAIL reset_gnt_follows: got %b want 1", bus.fetch_gnt_o); end
        vectors++; if (bus.fetch_rvalid_o !== 1'b0 || bus.fetch_err_o !== 1'b0 || bus.ld_err_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_regs: rvalid %b err %b lderr %b want 000", bus.fetch_rvalid_o, bus.fetch_err_o, bus.ld_err_o); end
        tick();
        vectors++; if (bus.fetch_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL reset_hold_rvalid: got %b want 0", bus.fetch_rvalid_o); end
        idle();
        losses = 0;
        @(negedge clk);
        vectors++; if (bus.fetch_gnt_o !== 1'b0 || bus.ld_gnt_o !== 1'b0 || bus.mem_en_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle: fgnt %b lgnt %b en %b want 000", bus.fetch_gnt_o, bus.ld_gnt_o, bus.mem_en_o); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.fetch_rvalid_o !== 1'b0 || bus.ld_err_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_release: rvalid %b lderr %b want 00", bus.fetch_rvalid_o, bus.ld_err_o); end
    endtask

    task automatic test_fetch_basic();
        apply(1'b1, 32'h0, 1'b0, '0, '0);
        @(negedge clk);
        vectors++; if (bus.fetch_gnt_o !== 1'b1 || bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b0 || bus.mem_idx_o !== '0) begin
            miscompares++; $display("FAIL basic_issue: gnt %b en %b we %b idx %0d want 1 1 0 0", bus.fetch_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_idx_o); end
        tick();
        idle();
        vectors++; if (bus.fetch_rvalid_o !== 1'b1 || bus.fetch_err_o !== 1'b0 || bus.fetch_rdata_o !== 32'h0010_0093) begin
            miscompares++; $display("FAIL basic_resp: rvalid %b err %b rdata %h want 1 0 00100093", bus.fetch_rvalid_o, bus.fetch_err_o, bus.fetch_rdata_o); end
        tick();
        vectors++; if (bus.fetch_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL basic_single: rvalid %b want 0", bus.fetch_rvalid_o); end
    endtask

    task automatic test_write_then_fetch();
        apply(1'b0, '0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        vectors++; if (bus.ld_gnt_o !== 1'b1 || bus.fetch_gnt_o !== 1'b0 || bus.mem_en_o !== 1'b1 || bus.mem_we_o !== 1'b1
                       || bus.mem_idx_o !== IW'(4) || bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL wr_issue: lgnt %b en %b we %b idx %0d wdata %h want 1 1 1 4 deadbeef",
                                    bus.ld_gnt_o, bus.mem_en_o, bus.mem_we_o, bus.mem_idx_o, bus.mem_wdata_o); end
        tick();
        apply(1'b1, 32'h10, 1'b0, '0, '0);
        vectors++; if (bus.ld_err_o !== 1'b0 || bus.fetch_rvalid_o !== 1'b0) begin
            miscompares++; $display("FAIL wr_no_resp: lderr %b rvalid %b want 00", bus.ld_err_o, bus.fetch_rvalid_o); end
        tick();
        idle();
        vectors++; if (bus.fetch_rvalid_o !== 1'b1 || bus.fetch_rdata_o !== 32'hDEAD_BEEF || bus.fetch_err_o !== 1'b0) begin
            miscompares++; $display("FAIL wr_readback: rvalid %b rdata %h err %b want 1 deadbeef 0", bus.fetch_rvalid_o, bus.fetch_rdata_o, bus.fetch_err_o); end
        tick();
    endtask

    task automatic test_fetch_errors();
        logic [AW-1:0] bad [4];
        bad[0] = 32'h2; bad[1] = AW'(MS * 4); bad[2] = 32'hFFFF_FFFC; bad[3] = 32'h1;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, bad[i], 1'b0, '0, '0);
            @(negedge clk);
            vectors++; if (bus.fetch_gnt_o !== 1'b1 || bus.mem_en_o !== 1'b0) begin
                miscompares++; $display("FAIL ferr_issue addr %h: gnt %b en %b want 1 0", bad[i], bus.fetch_gnt_o, bus.mem_en_o); end
            tick();
            vectors++; if (bus.fetch_rvalid_o !== 1'b1 || bus.fetch_err_o !== 1'b1 || bus.fetch_rdata_o !== 32'h0000_0013) begin
                miscompares++; $display("FAIL ferr_resp addr %h: rvalid %b err %b rdata %h want 1 1 00000013",
                                        bad[i], bus.fetch_rvalid_o, bus.fetch_err_o, bus.fetch_rdata_o); end
        end
        idle();
        tick();
        vectors++; if (bus.fetch_err_o !== 1'b0) begin miscompares++; $display("FAIL ferr_clear: err %b want 0", bus.fetch_err_o); end
    endtask

    task automatic test_loader_error();
        apply(1'b0, '0, 1'b1, 32'h1003, 32'h1234_5678);
        @(negedge clk);
        vectors++; if (bus.ld_gnt_o !== 1'b1 || bus.mem_en_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
            miscompares++; $display("FAIL lerr_issue: lgnt %b en %b we %b want 1 0 0", bus.ld_gnt_o, bus.mem_en_o, bus.mem_we_o); end
        tick();
        idle();
        vectors++; if (bus.ld_err_o !== 1'b1) begin miscompares++; $display("FAIL lerr_pulse: got %b want 1", bus.ld_err_o); end
        tick();
        vectors++; if (bus.ld_err_o !== 1'b0) begin miscompares++; $display("FAIL lerr_one_cycle: got %b want 0", bus.ld_err_o); end
    endtask

    task automatic test_starvation();
        bit want_f;
        for (int i = 0; i < 15; i++) begin
            want_f = (i % 5 == 4);
            apply(1'b1, AW'(4 * i), 1'b1, AW'(32'h100 + 4 * i), $urandom);
            @(negedge clk);
            vectors++; if (bus.fetch_gnt_o !== want_f || bus.ld_gnt_o !== !want_f) begin
                miscompares++; $display("FAIL starve cyc %0d: fgnt %b lgnt %b want %b %b", i, bus.fetch_gnt_o, bus.ld_gnt_o, want_f, !want_f); end
            tick();
            vectors++; if (bus.fetch_rvalid_o !== want_f || (want_f && bus.fetch_rdata_o !== n_rdata)) begin
                miscompares++; $display("FAIL starve_resp cyc %0d: rvalid %b rdata %h want %b %h", i, bus.fetch_rvalid_o, bus.fetch_rdata_o, want_f, n_rdata); end
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, AW'(4 * $urandom_range(0, MS - 1)), 1'b0, '0, '0);
            tick();
            vectors++; if (bus.fetch_rvalid_o !== 1'b1 || bus.fetch_err_o !== 1'b0 || bus.fetch_rdata_o !== n_rdata) begin
                miscompares++; $display("FAIL b2b %0d addr %h: rvalid %b err %b rdata %h want 1 0 %h",
                                        i, f_addr, bus.fetch_rvalid_o, bus.fetch_err_o, bus.fetch_rdata_o, n_rdata); end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 32'h8, 1'b0, '0, '0);
        tick();
        idle();
        vectors++; if (bus.fetch_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL rmid_pre: rvalid %b want 1", bus.fetch_rvalid_o); end
        #1 rst_n = 1'b0;
        losses = 0;
        #1;
        vectors++; if (bus.fetch_rvalid_o !== 1'b0 || bus.fetch_err_o !== 1'b0) begin
            miscompares++; $display("FAIL rmid_drop: rvalid %b err %b want 00", bus.fetch_rvalid_o, bus.fetch_err_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.fetch_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rmid_after: rvalid %b want 0", bus.fetch_rvalid_o); end
        // Leave the starvation counter part-way up, then reset and expect a full window.
        for (int i = 0; i < 2; i++) begin apply(1'b1, 32'h0, 1'b1, 32'h200, 32'h0); tick(); end
        idle();
        #1 rst_n = 1'b0;
        losses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 32'h0, 1'b1, 32'h204, 32'h0);
            @(negedge clk);
            vectors++; if (bus.fetch_gnt_o !== (i == 4)) begin
                miscompares++; $display("FAIL rmid_cnt_clear cyc %0d: fgnt %b want %b", i, bus.fetch_gnt_o, (i == 4)); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit fp = 1'b0, lp = 1'b0;
        logic [AW-1:0] fa = '0, la = '0;
        logic [DW-1:0] lw = '0;
        for (int c = 0; c < 400; c++) begin
            if (!fp && $urandom_range(0, 9) < 6) begin fp = 1'b1; fa = rand_addr(); end
            else if (fp && $urandom_range(0, 19) == 0) fp = 1'b0;
            if (!lp && $urandom_range(0, 9) < 5) begin lp = 1'b1; la = rand_addr(); lw = $urandom; end
            else if (lp && $urandom_range(0, 19) == 0) lp = 1'b0;
            apply(fp, fa, lp, la, lw);
            @(negedge clk);
            vectors++; if (bus.fetch_gnt_o !== e_fgnt || bus.ld_gnt_o !== e_lgnt) begin
                miscompares++; $display("FAIL rnd_gnt cyc %0d: fgnt %b lgnt %b want %b %b", c, bus.fetch_gnt_o, bus.ld_gnt_o, e_fgnt, e_lgnt); end
            vectors++; if (bus.mem_en_o !== e_en || bus.mem_we_o !== e_we || (e_en && bus.mem_idx_o !== e_idx) || (e_we && bus.mem_wdata_o !== e_wdata)) begin
                miscompares++; $display("FAIL rnd_mem cyc %0d: en %b we %b idx %0d wd %h want %b %b %0d %h",
                                        c, bus.mem_en_o, bus.mem_we_o, bus.mem_idx_o, bus.mem_wdata_o, e_en, e_we, e_idx, e_wdata); end
            if (e_fgnt) fp = 1'b0;
            if (e_lgnt) lp = 1'b0;
            tick();
            vectors++; if (bus.fetch_rvalid_o !== n_rvalid || bus.fetch_err_o !== n_err || bus.ld_err_o !== n_lderr) begin
                miscompares++; $display("FAIL rnd_flags cyc %0d: rvalid %b err %b lderr %b want %b %b %b",
                                        c, bus.fetch_rvalid_o, bus.fetch_err_o, bus.ld_err_o, n_rvalid, n_err, n_lderr); end
            if (n_rvalid) begin
                vectors++; if (bus.fetch_rdata_o !== n_rdata) begin
                    miscompares++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, bus.fetch_rdata_o, n_rdata); end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        losses = 0;
        for (int i = 0; i < int'(MS); i++) ref_mem[i] = init_word(i);
        test_reset();
        test_fetch_basic();
        test_write_then_fetch();
        test_fetch_errors();
        test_loader_error();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port access controller for the core's instruction memory: arbitrates each cycle between the instruction-fetch stage (read) and a program loader (write, e.g. debug/boot path). It drives a synchronous single-port word memory, returns fetch data one cycle after grant, and converts misaligned or out-of-range fetches into a NOP response. Sits between the fetch stage and the instruction memory array.

## Interface
- DATA_WIDTH, 32, instruction/word width
- ADDR_WIDTH, 32, byte address width of both requesters
- MEM_SIZE, 1024, memory depth in words (power of two, ≥2)
- MAX_FETCH_WAIT, 4, consecutive cycles fetch may lose to loader before it is forced to win (≥1)
- IDX_W (localparam) = $clog2(MEM_SIZE)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req_i  in  1  fetch read request
- fetch_addr_i  in  ADDR_WIDTH  fetch byte address
- fetch_gnt_o  out  1  fetch accepted this cycle (combinational)
- fetch_rvalid_o  out  1  response valid (registered, one cycle after grant)
- fetch_rdata_o  out  DATA_WIDTH  instruction, valid with fetch_rvalid_o
- fetch_err_o  out  1  response is error-substituted NOP, valid with fetch_rvalid_o
- ld_req_i  in  1  loader write request
- ld_addr_i  in  ADDR_WIDTH  loader byte address
- ld_wdata_i  in  DATA_WIDTH  loader write data
- ld_gnt_o  out  1  loader accepted this cycle (combinational)
- ld_err_o  out  1  one-cycle pulse, cycle after a granted out-of-range/misaligned write
- mem_en_o  out  1  memory access enable
- mem_we_o  out  1  write enable
- mem_idx_o  out  IDX_W  word index
- mem_wdata_o  out  DATA_WIDTH  write data
- mem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a read enable

## Operation
- Address check (per requester): index = addr >> 2; valid iff addr[1:0]==0 and (addr >> 2) < MEM_SIZE. mem_idx_o = (addr >> 2) truncated to IDX_W bits.
- Arbitration, one grant per cycle max:
  - only one requesting: it is granted.
  - both requesting: loader wins unless wait_cnt == MAX_FETCH_WAIT, then fetch wins.
- wait_cnt (width $clog2(MAX_FETCH_WAIT+1)): +1 on each cycle fetch_req_i=1 and loader granted; cleared on fetch grant or fetch_req_i=0; saturates at MAX_FETCH_WAIT.
- Granted valid fetch: mem_en_o=1, mem_we_o=0. Granted invalid fetch: mem_en_o=0, response still produced.
- Granted valid loader write: mem_en_o=1, mem_we_o=1, mem_wdata_o=ld_wdata_i. Granted invalid write: mem_en_o=0 (dropped), ld_err_o pulses next cycle.
- Response register (rvalid_q, err_q) loads {fetch_gnt_o, fetch_gnt_o & invalid} each cycle.
- fetch_rdata_o = err_q ? 32'h00000013 : mem_rdata_i; fetch_err_o = rvalid_q & err_q.
- No grant: mem_en_o=0, mem_we_o=0; mem_idx_o/mem_wdata_o don't-care (drive 0).
- Requesters hold request/address/data until granted; a deasserted request before grant is simply withdrawn.

## Timing
- Reset (async assert, sync release): fetch_rvalid_o=0, fetch_err_o=0, ld_err_o=0, wait_cnt=0; combinational outputs follow inputs (no grants if no requests).
- Fetch latency: grant in cycle t, fetch_rvalid_o/fetch_rdata_o in t+1. Back-to-back fetch grants give one response per cycle.
- Write in cycle t is visible to a fetch granted in t+1 or later.
- Reset mid-operation: pending response discarded (rvalid 0), wait_cnt cleared; any write in the reset cycle is not guaranteed.
- Starvation bound: with both requesting continuously, fetch granted at least once every MAX_FETCH_WAIT+1 cycles.

## Test plan
- Reset, then fetch_req_i=1, addr 0x0, memory word 0 = 0x00100093 -> gnt same cycle, next cycle rvalid=1, rdata=0x00100093, err=0.
- Loader writes 0xDEADBEEF to addr 0x10, fetch of 0x10 next cycle -> mem_we_o=1 idx=4, then rvalid with rdata=0xDEADBEEF.
- Fetch addr 0x2 and addr MEM_SIZE*4 -> mem_en_o=0, next cycle rvalid=1, err=1, rdata=0x00000013.
- Both requesting continuously, MAX_FETCH_WAIT=4 -> grants L,L,L,L,F repeating; wait_cnt clears after each F.
- Loader write to addr 0x1003 -> ld_gnt_o=1, mem_en_o=0, ld_err_o=1 next cycle only.
- rst_n asserted the cycle after a fetch grant -> fetch_rvalid_o=0 immediately, no response after release.
